top_core_isqrt: RTL
===================

// Module: top_core_isqrt
// PURPOSE
//  Inverse of top_core: takes an 8-bit value n2 and returns its integer square
//  root n (4 bits) plus the remainder, so that n2 == n*n + rem.
//  Iterative restoring digit-by-digit root: one result bit per clock.
//  Sits beside top_core instances in the coverage-merge tops, so benches can
//  round-trip n -> n2 -> n.
//  Valid/ready handshake on both the input and the output side.
// PARAMETERS
//  IN_W   8         width of n2 input; must be even and >= 2
//  OUT_W  IN_W/2    width of root output n (derived; not overridable)
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        synchronous reset, active-high
//  in_valid   in   1        n2 is valid this cycle
//  in_ready   out  1        block accepts n2 (high only in IDLE)
//  n2         in   IN_W     radicand
//  out_valid  out  1        n/rem valid; held until accepted
//  out_ready  in   1        consumer accepts the result
//  n          out  OUT_W    floor(sqrt(n2))
//  rem        out  OUT_W+1  n2 - n*n (max 2*n, i.e. 30 for IN_W=8)
// BEHAVIOUR
//  - Reset, sampled on clk: state=IDLE, in_ready=1, out_valid=0, n=0, rem=0,
//    internal root/rem/radicand registers=0. Reset overrides every other event.
//  - FSM IDLE -> CALC -> DONE -> IDLE.
//   IDLE: in_ready=1. When in_valid&in_ready: latch n2, clear root/rem,
//         load iteration counter cnt=OUT_W-1, go to CALC.
//   CALC: in_ready=0. Each cycle, for bit pair i=cnt:
//         r' = (rem<<2) | n2[2i+1:2i];  t = (root<<2) | 1;
//         if r' >= t then rem=r'-t, root=(root<<1)|1; else rem=r', root=root<<1.
//         Internal rem register is OUT_W+2 bits; the compare is unsigned at
//         that width, with no truncation.
//         At cnt==0, after that cycle's step: go to DONE. cnt decrements
//         otherwise and never wraps.
//   DONE: out_valid=1; n and rem hold the final values, stable until the
//         handshake. On out_valid&out_ready: out_valid=0 and go to IDLE.
//         in_ready stays 0 in DONE; there is no input/output overlap.
//  - Latency: accept at edge k; out_valid rises after edge k+OUT_W (4 for the
//    default). Max throughput: one result per OUT_W+2 cycles.
//  - n and rem update only on the transition into DONE; otherwise they hold
//    their last value.
//  - in_valid in CALC or DONE is ignored. The upstream must hold n2 until it
//    is accepted.
//  - out_ready low stalls DONE indefinitely. Results are never dropped.
//  - Reset mid-CALC or mid-DONE aborts the operation and the pending result
//    is lost. No out_valid pulse follows.
//  - n2=0 -> n=0, rem=0. n2=2**IN_W-1 -> n=2**OUT_W-1, rem=2*(2**OUT_W-1).
// STRUCTURE
//  - Package top_core_isqrt_pkg holds:
//    - the state enum (IDLE, CALC, DONE), 2 bits;
//    - the default width localparams IN_W_DEF=8 and OUT_W_DEF=4.
//  - Sub-module isqrt_step: purely combinational, one digit iteration.
//    - Inputs: root, rem, bit pair.
//    - Outputs: root_nxt, rem_nxt.
//    - Instantiated once in CALC; keeps the FSM file small and gives
//      isqrt_step its own coverage.
//  - Top: FSM, cnt register (clog2(OUT_W) bits), n2 register, handshakes.
// TESTING
//  1 Reset, then n2=0 -> out_valid 4 cycles after accept; n=0, rem=0.
//  2 n2=144 -> n=12, rem=0. n2=143 -> n=11, rem=22. n2=255 -> n=15, rem=30.
//  3 Stall: out_ready=0 for 10 cycles in DONE -> n/rem stable,
//    in_ready=0, a second in_valid is ignored. Release -> IDLE next cycle.
//  4 Reset asserted 2 cycles into CALC (n2=200) -> next cycle out_valid=0,
//    in_ready=1. A new n2=49 then yields n=7, rem=0.
//  5 Exhaustive 0..255, back-to-back with out_ready=1: n*n+rem==n2 and
//    rem<=2n. Feed each n through top_core and check n2 == n*n.
//  6 Random in_valid/out_ready toggling, 1000 ops vs reference model.
//    Cover every FSM transition; zero dropped or duplicated results.

Source files
------------

// File: rtl/top_core_isqrt_pkg.sv
// Shared types and default widths for the integer square-root block.
//   state_e    : FSM state encoding (idle, iterating, result pending)
//   IN_W_DEF   : default radicand width
//   OUT_W_DEF  : default root width (half the radicand width)
package top_core_isqrt_pkg;

  localparam int unsigned IN_W_DEF  = 8;
  localparam int unsigned OUT_W_DEF = IN_W_DEF / 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/isqrt_step.sv
// One digit of a restoring binary square root. Purely combinational.
//   root     : partial root so far
//   rem      : partial remainder so far
//   pair     : next two radicand bits, most significant pair first
//   root_nxt : partial root with one more result bit appended
//   rem_nxt  : updated partial remainder
module isqrt_step #(
  parameter int unsigned OUT_W = 4
) (
  input  logic [OUT_W-1:0] root,
  input  logic [OUT_W+1:0] rem,
  input  logic [1:0]       pair,
  output logic [OUT_W-1:0] root_nxt,
  output logic [OUT_W+1:0] rem_nxt
);

  logic [OUT_W+1:0] r_sh;
  logic [OUT_W+1:0] trial;
  logic             ge;

  // The partial remainder never exceeds 2*root, so its top two bits are always
  // zero on entry and can be shifted out without losing information.
  logic unused_rem_hi;
  assign unused_rem_hi = ^rem[OUT_W+1:OUT_W];

  always_comb begin
    r_sh     = {rem[OUT_W-1:0], pair};
    trial    = {root, 2'b01};
    ge       = (r_sh >= trial);
    rem_nxt  = ge ? (r_sh - trial) : r_sh;
    root_nxt = (root << 1) | OUT_W'(ge);
  end

endmodule

// File: rtl/top_core_isqrt.sv
// Iterative integer square root: n = floor(sqrt(n2)), rem = n2 - n*n.
// One result bit per clock, valid/ready handshakes on both sides.
//   clk, rst  : clock and synchronous active-high reset
//   in_valid  : n2 is valid this cycle
//   in_ready  : block accepts n2 (only while idle)
//   n2        : radicand, IN_W bits (IN_W must be even and >= 2)
//   out_valid : n/rem valid, held until out_ready
//   out_ready : consumer accepts the result
//   n         : root, IN_W/2 bits
//   rem       : remainder, IN_W/2+1 bits
module top_core_isqrt
  import top_core_isqrt_pkg::*;
#(
  parameter  int unsigned IN_W  = IN_W_DEF,
  localparam int unsigned OUT_W = IN_W / 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  n2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] n,
  output logic [OUT_W:0]   rem
);

  localparam int unsigned CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  state_e           state_q;
  logic [IN_W-1:0]  n2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [OUT_W-1:0] root_q;
  logic [OUT_W+1:0] part_rem_q;
  logic [OUT_W-1:0] n_q;
  logic [OUT_W:0]   rem_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [1:0]       pair;
  logic [OUT_W-1:0] root_nxt;
  logic [OUT_W+1:0] rem_nxt;

  // The final remainder is bounded by 2*n, so the top bit is always zero.
  logic unused_rem_nxt_hi;
  assign unused_rem_nxt_hi = rem_nxt[OUT_W+1];

  assign pair = n2_q[{cnt_q, 1'b0} +: 2];

  isqrt_step #(
    .OUT_W (OUT_W)
  ) u_step (
    .root     (root_q),
    .rem      (part_rem_q),
    .pair     (pair),
    .root_nxt (root_nxt),
    .rem_nxt  (rem_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      n2_q        <= '0;
      cnt_q       <= '0;
      root_q      <= '0;
      part_rem_q  <= '0;
      n_q         <= '0;
      rem_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            n2_q       <= n2;
            root_q     <= '0;
            part_rem_q <= '0;
            cnt_q      <= CNT_W'(OUT_W - 1);
            in_ready_q <= 1'b0;
            state_q    <= StCalc;
          end
        end
        StCalc: begin
          root_q     <= root_nxt;
          part_rem_q <= rem_nxt;
          if (cnt_q == '0) begin
            n_q         <= root_nxt;
            rem_q       <= rem_nxt[OUT_W:0];
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign n         = n_q;
  assign rem       = rem_q;

endmodule
